// File: rtl/sum_bcd_display_pkg.sv
// Shared types and seven-segment constants for the sum-to-BCD display block.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package sum_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    // Index n holds the code for digit n (index 9 is the leftmost entry).
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: seg = SEG_DIGITS[digit];
            default:                      seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= 4'd5) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/sum_bcd_display_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank override.
module seg7_digit
    import sum_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode one digit, forcing all segments off when blanked.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg7_encode(digit);
        end
    end

endmodule

// File: rtl/sum_bcd_display.sv
// Converts the accumulator value {carry,sum} to three BCD digits by double dabble,
// one iteration per clock, and drives four seven-segment displays.
module sum_bcd_display
    import sum_bcd_display_pkg::*;
#(
    parameter bit BLANK_LEAD = 1'b1,
    parameter int ITER       = 9
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic [7:0]  sum,
    input  logic        carry,
    input  logic        overflow,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    localparam int             CW       = $clog2(ITER + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(ITER - 1);
    localparam logic [6:0]     LEAD_RST = BLANK_LEAD ? SEG_BLANK : SEG_DIGITS[0];

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [ITER-1:0]   val_r;
    logic [11:0]       scratch_r;
    logic              ovf_r;
    logic [11:0]       adj_s;
    logic [11:0]       scratch_nxt_s;
    logic              capture_s;
    logic              load_s;
    logic              busy_nxt_s;
    logic              blank2_s;
    logic              blank1_s;
    logic [6:0]        seg2_s;
    logic [6:0]        seg1_s;
    logic [6:0]        seg0_s;
    logic              busy_r;
    logic              done_r;
    logic [11:0]       bcd_r;
    logic [6:0]        hex3_r;
    logic [6:0]        hex2_r;
    logic [6:0]        hex1_r;
    logic [6:0]        hex0_r;

    // One double-dabble step: add-3 correction, then shift in the next value bit.
    always_comb begin
        adj_s = {dd_adjust(scratch_r[11:8]), dd_adjust(scratch_r[7:4]), dd_adjust(scratch_r[3:0])};
        scratch_nxt_s = 12'({adj_s, val_r[ITER-1]});
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        load_s      = 1'b0;
        busy_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT;
                    capture_s   = 1'b1;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The last shift result goes straight to the outputs so done and digits align.
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_SHIFT;
                    busy_nxt_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Leading-zero blanking computed on the digits about to be loaded.
    always_comb begin
        blank2_s = BLANK_LEAD && (scratch_nxt_s[11:8] == 4'd0);
        blank1_s = blank2_s && (scratch_nxt_s[7:4] == 4'd0);
    end

    seg7_digit u_seg2 (.digit(scratch_nxt_s[11:8]), .blank(blank2_s), .seg(seg2_s));
    seg7_digit u_seg1 (.digit(scratch_nxt_s[7:4]),  .blank(blank1_s), .seg(seg1_s));
    seg7_digit u_seg0 (.digit(scratch_nxt_s[3:0]),  .blank(1'b0),     .seg(seg0_s));

    // FSM state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture and shift datapath.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_r     <= '0;
            val_r     <= '0;
            scratch_r <= 12'h000;
            ovf_r     <= 1'b0;
        end else if (capture_s) begin
            cnt_r     <= '0;
            val_r     <= ITER'({carry, sum});
            scratch_r <= 12'h000;
            ovf_r     <= overflow;
        end else if (state_r == ST_SHIFT) begin
            cnt_r     <= cnt_r + CW'(1);
            val_r     <= val_r << 1;
            scratch_r <= scratch_nxt_s;
        end
    end

    // Registered status and display outputs; digits change only when a result completes.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bcd_r  <= 12'h000;
            hex3_r <= SEG_BLANK;
            hex2_r <= LEAD_RST;
            hex1_r <= LEAD_RST;
            hex0_r <= SEG_DIGITS[0];
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= load_s;
            if (load_s) begin
                bcd_r  <= scratch_nxt_s;
                hex3_r <= ovf_r ? SEG_F : SEG_BLANK;
                hex2_r <= seg2_s;
                hex1_r <= seg1_s;
                hex0_r <= seg0_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;
    assign HEX3 = hex3_r;
    assign HEX2 = hex2_r;
    assign HEX1 = hex1_r;
    assign HEX0 = hex0_r;

endmodule

// File: doc/sum_bcd_display.md
SUM_BCD_DISPLAY -- requirements
Module: sum_bcd_display

Interface
REQ-001 Parameter BLANK_LEAD, default 1, meaning: when 1, leading-zero digits on HEX2/HEX1 are blanked.
REQ-002 Parameter ITER, default 9, meaning: number of shift iterations, equal to the input value width ({carry,sum}).
REQ-003 Clock  input  1  rising-edge system clock; the one and only clock.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a conversion of the current sum/carry/overflow; level-sampled on each Clock rising edge.
REQ-006 sum  input  8  accumulator sum, from the accumulator stage's LEDR[7:0] equivalent.
REQ-007 carry  input  1  accumulator carry-out, treated as bit 8 of the value.
REQ-008 overflow  input  1  accumulator signed-overflow flag.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when new digits are valid.
REQ-011 bcd  output  12  {hundreds,tens,ones} BCD digits of the last completed conversion.
REQ-012 HEX3, HEX2, HEX1, HEX0  output  7 each  active-low seven-segment codes, bit 6 = g ... bit 0 = a.

Function
REQ-013 The block SHALL convert V = {carry,sum} (0..511) to three BCD digits using shift-and-add-3 (double dabble), one iteration per clock.
REQ-014 FSM states SHALL be IDLE, SHIFT, and DONE; the reset state SHALL be IDLE.
REQ-015 IDLE -> SHIFT on start=1: at that edge, V and overflow SHALL be captured, the iteration counter cleared, and the BCD scratch register zeroed.
REQ-016 In SHIFT, each cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch,V} left by one; after ITER iterations the FSM SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle, load bcd/HEX outputs from the scratch register, assert done, and return to IDLE.
REQ-018 Latency: start sampled at edge k -> busy=1 from k+1 through k+ITER -> done=1 and outputs updated during cycle k+ITER+1 (10 cycles for ITER=9).
REQ-019 start SHALL be ignored while busy=1 or during DONE; no request queuing.
REQ-020 start held high SHALL launch back-to-back conversions, one per ITER+2 cycles.
REQ-021 sum/carry/overflow changes after the capture edge SHALL NOT affect the conversion in progress.
REQ-022 bcd and HEX outputs SHALL hold their previous values until the DONE cycle; no partial results SHALL be visible.
REQ-023 HEX0 SHALL always show the ones digit; with BLANK_LEAD=1, HEX2 SHALL be blank (7'h7F) when hundreds=0, and HEX1 SHALL be blank when hundreds=0 and tens=0.
REQ-024 HEX3 SHALL show 'F' (7'b0001110) when the captured overflow=1, and blank otherwise.
REQ-025 Digit encodings 0-9 SHALL be standard active-low codes ('0'=7'b1000000, '5'=7'b0010010).

Reset
REQ-026 Resetn=0 SHALL immediately force: state=IDLE, busy=0, done=0, bcd=12'h000, counter=0, and the captured overflow=0.
REQ-027 On reset, HEX0 SHALL show '0', and HEX1/HEX2/HEX3 SHALL be blank (with BLANK_LEAD=0, HEX1/HEX2 SHALL show '0').
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after release SHALL begin a fresh conversion.

Structure
REQ-029 The shared package SHALL hold the state encoding and the segment constants: SEG_BLANK, SEG_F, and the digit table.
REQ-030 The BCD-to-seven-segment decode SHALL be one combinational sub-module, seg7_digit, instantiated three times for HEX0..HEX2.
REQ-031 The FSM, iteration counter, and scratch datapath SHALL reside in sum_bcd_display itself.

Verification
REQ-032 Reset, then sum=0, carry=0, start pulse -> done at cycle 10; bcd=000; HEX0='0'; HEX1/HEX2/HEX3 blank.
REQ-033 sum=8'hFF, carry=0, overflow=0 -> bcd=255; HEX2='2', HEX1='5', HEX0='5'; HEX3 blank.
REQ-034 sum=8'hFF, carry=1, overflow=1 -> bcd=511; HEX3='F'.
REQ-035 sum=8'd7, start pulse; at cycle 3 change sum=8'd200 and pulse start again -> one done only, bcd=007; HEX1/HEX2 blank.
REQ-036 sum=8'd128, start; assert Resetn=0 at cycle 5 -> no done pulse, reset values on all outputs; re-start after release -> bcd=128 ten cycles later.
REQ-037 start held high for 30 cycles with sum=8'd99 -> done pulses at cycles 10, 21, and 32 relative to the first sampled edge (every 11 cycles); bcd=099 each time.
